// File: rtl/i2c_arb_pkg.sv
// Shared types and default timing constants for the two-requester I2C EEPROM arbiter.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StBusy,
        StTwr,
        StDone
    } arb_state_e;

    localparam int unsigned DefStartHold  = 50;
    localparam int unsigned DefTwrCyc     = 250_000;
    localparam int unsigned DefTimeoutCyc = 2_000_000;

endpackage

// File: rtl/i2c_rr_grant.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the side ptr favours.
module i2c_rr_grant
    import i2c_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Sequences an external I2C EEPROM controller on behalf of two requesters.
// Optional transaction timeout is compiled in with `define I2C_ARB_TIMEOUT_EN.
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned START_HOLD  = DefStartHold,
    parameter int unsigned TWR_CYC     = DefTwrCyc,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        req0,
    input  logic        wr0,
    input  logic [15:0] addr0,
    input  logic [7:0]  wdata0,
    input  logic        req1,
    input  logic        wr1,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [7:0]  rdata,
    output logic        err,
    output logic        i2c_start,
    output logic        wr_en,
    output logic        rd_en,
    output logic [15:0] byte_addr,
    output logic [7:0]  wr_data,
    input  logic        i2c_end,
    input  logic [7:0]  rd_data
);

    localparam int unsigned CntMax = (START_HOLD > TWR_CYC) ? START_HOLD : TWR_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    arb_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic            ptr_q;
    logic            owner_q;
    logic [2:0]      end_sync_q;
    logic [1:0]      rr_gnt;
    logic            end_rise;
    logic            timeout;

    i2c_rr_grant u_rr_grant (
        .req ({req1, req0}),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

    // Bits [1:0] are the synchroniser, bit 2 holds the previous synchronised level.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            end_sync_q <= '0;
        end else begin
            end_sync_q <= {end_sync_q[1:0], i2c_end};
        end
    end

    assign end_rise = end_sync_q[1] & ~end_sync_q[2];

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);

    logic [ToW-1:0] to_cnt_q;

    assign timeout = ((state_q == StStart) || (state_q == StBusy)) &&
                     (to_cnt_q == ToW'(TIMEOUT_CYC - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            to_cnt_q <= '0;
            err      <= 1'b0;
        end else begin
            err <= timeout;
            if (state_q == StIdle) begin
                to_cnt_q <= '0;
            end else if (((state_q == StStart) || (state_q == StBusy)) &&
                         (to_cnt_q != ToW'(TIMEOUT_CYC))) begin
                to_cnt_q <= to_cnt_q + ToW'(1);
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;

    // TIMEOUT_CYC has no effect in this build.
    if (TIMEOUT_CYC == 0) begin : g_timeout_off
    end
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata     <= '0;
            i2c_start <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            byte_addr <= '0;
            wr_data   <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|rr_gnt) begin
                        owner_q   <= rr_gnt[1];
                        gnt0      <= rr_gnt[0];
                        gnt1      <= rr_gnt[1];
                        byte_addr <= rr_gnt[1] ? addr1 : addr0;
                        wr_data   <= rr_gnt[1] ? wdata1 : wdata0;
                        wr_en     <= rr_gnt[1] ? wr1 : wr0;
                        rd_en     <= rr_gnt[1] ? ~wr1 : ~wr0;
                        cnt_q     <= '0;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    if (timeout) begin
                        i2c_start <= 1'b0;
                        done0     <= ~owner_q;
                        done1     <= owner_q;
                        state_q   <= StDone;
                    end else if (!i2c_start) begin
                        // First START cycle: gives the one-cycle grant-to-start latency.
                        i2c_start <= 1'b1;
                        cnt_q     <= '0;
                    end else if (cnt_q == CntW'(START_HOLD - 1)) begin
                        i2c_start <= 1'b0;
                        state_q   <= StBusy;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StBusy: begin
                    if (timeout) begin
                        done0   <= ~owner_q;
                        done1   <= owner_q;
                        state_q <= StDone;
                    end else if (end_rise) begin
                        if (wr_en) begin
                            cnt_q   <= '0;
                            state_q <= StTwr;
                        end else begin
                            rdata   <= rd_data;
                            done0   <= ~owner_q;
                            done1   <= owner_q;
                            state_q <= StDone;
                        end
                    end
                end
                StTwr: begin
                    if (cnt_q == CntW'(TWR_CYC - 1)) begin
                        done0   <= ~owner_q;
                        done1   <= owner_q;
                        state_q <= StDone;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    wr_en   <= 1'b0;
                    rd_en   <= 1'b0;
                    ptr_q   <= ~owner_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter with a behavioural EEPROM controller and arbitration model.
module tb_i2c_arbiter;

    localparam int unsigned StartHold  = 6;
    localparam int unsigned TwrCyc     = 40;
    localparam int unsigned TimeoutCyc = 300;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, done0, done1, err, i2c_start, wr_en, rd_en;
    logic [7:0]  rdata, wr_data;
    logic [15:0] byte_addr;
    logic        i2c_end = 1'b0;
    logic [7:0]  rd_data = '0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    i2c_arbiter #(
        .START_HOLD  (StartHold),
        .TWR_CYC     (TwrCyc),
        .TIMEOUT_CYC (TimeoutCyc)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req0      (req0),
        .wr0       (wr0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .wr1       (wr1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .rdata     (rdata),
        .err       (err),
        .i2c_start (i2c_start),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .byte_addr (byte_addr),
        .wr_data   (wr_data),
        .i2c_end   (i2c_end),
        .rd_data   (rd_data)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Observation records, filled on the falling edge.
    int          t_gnt, t_start, t_end, t_done, start_hi, err_cnt;
    int          done_cnt [2];
    int          grant_q[$];
    int          grant_t_q[$];
    int          done_t_q[$];
    logic [7:0]  done_rdata;
    logic        done_err;
    logic        cmd_chg;
    logic [25:0] snap;
    logic        gnt0_d = 1'b0, gnt1_d = 1'b0, start_d = 1'b0;

    // EEPROM/controller environment model.
    logic [7:0]  eeprom [logic [15:0]];
    logic        ctrl_hang = 1'b0;
    logic        ctrl_start_d = 1'b0;
    int          end_at = -1;

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (gnt0 && !gnt0_d) begin
                t_gnt = cyc; grant_q.push_back(0); grant_t_q.push_back(cyc);
                snap = {byte_addr, wr_data, wr_en, rd_en};
            end else if (gnt1 && !gnt1_d) begin
                t_gnt = cyc; grant_q.push_back(1); grant_t_q.push_back(cyc);
                snap = {byte_addr, wr_data, wr_en, rd_en};
            end else if ((gnt0 || gnt1) && ({byte_addr, wr_data, wr_en, rd_en} != snap)) begin
                cmd_chg = 1'b1;
            end
            if (i2c_start && !start_d) t_start = cyc;
            if (i2c_start) start_hi++;
            if (done0 || done1) begin
                t_done = cyc; done_rdata = rdata; done_err = err; done_t_q.push_back(cyc);
            end
            if (done0) done_cnt[0]++;
            if (done1) done_cnt[1]++;
            if (err) err_cnt++;
        end
        gnt0_d  = gnt0;
        gnt1_d  = gnt1;
        start_d = i2c_start;
    end

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            i2c_end = 1'b0;
            end_at  = -1;
        end else begin
            if (ctrl_start_d && !i2c_start) end_at = cyc + int'($urandom_range(1, 6));
            if (!ctrl_hang && end_at == cyc) begin
                if (wr_en) eeprom[byte_addr] = wr_data;
                rd_data = eeprom.exists(byte_addr) ? eeprom[byte_addr] : 8'hFF;
                i2c_end = 1'b1;
                t_end   = cyc;
                end_at  = -1;
            end
            if (done0 || done1) i2c_end = 1'b0;
        end
        ctrl_start_d = i2c_start;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_mon();
        t_gnt = -1; t_start = -1; t_end = -1; t_done = -1; start_hi = 0; err_cnt = 0;
        done_cnt[0] = 0; done_cnt[1] = 0;
        grant_q.delete(); grant_t_q.delete(); done_t_q.delete();
        done_rdata = 'x; done_err = 1'bx; cmd_chg = 1'b0; snap = '0;
    endtask

    task automatic apply_reset();
        sys_rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        clear_mon();
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        int base;
        base = done_cnt[0] + done_cnt[1];
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt[0] + done_cnt[1] != base) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        n_vec++;
        if ({gnt0, gnt1, done0, done1, err} !== 5'b0) begin
            n_err++; $display("FAIL reset_handshake: got %b want 00000", {gnt0, gnt1, done0, done1, err});
        end
        n_vec++;
        if ({i2c_start, wr_en, rd_en} !== 3'b0) begin
            n_err++; $display("FAIL reset_cmd: got %b want 000", {i2c_start, wr_en, rd_en});
        end
        n_vec++;
        if ({byte_addr, wr_data, rdata} !== 32'h0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {byte_addr, wr_data, rdata});
        end
        #1 sys_rst_n = 1'b1;
        clear_mon();
        tick();
        n_vec++;
        if ({gnt0, gnt1, i2c_start} !== 3'b0) begin
            n_err++; $display("FAIL reset_idle: got %b want 000", {gnt0, gnt1, i2c_start});
        end
    endtask

    task automatic test_write();
        bit to;
        int t_req;
        clear_mon();
        wr0 = 1'b1; addr0 = 16'h0010; wdata0 = 8'hA5; req0 = 1'b1;
        t_req = cyc;
        wait_done(StartHold + TwrCyc + 40, to);
        req0 = 1'b0;
        n_vec++;
        if (to) begin n_err++; $display("FAIL write_done_seen: got none want done0"); end
        n_vec++;
        if (t_gnt - t_req != 1) begin
            n_err++; $display("FAIL write_gnt_latency: got %0d want 1", t_gnt - t_req);
        end
        n_vec++;
        if (t_start - t_gnt != 1) begin
            n_err++; $display("FAIL write_start_latency: got %0d want 1", t_start - t_gnt);
        end
        n_vec++;
        if (start_hi != int'(StartHold)) begin
            n_err++; $display("FAIL write_start_width: got %0d want %0d", start_hi, StartHold);
        end
        n_vec++;
        if (snap !== {16'h0010, 8'hA5, 1'b1, 1'b0} || cmd_chg) begin
            n_err++; $display("FAIL write_cmd: got %h chg %b want %h", snap, cmd_chg,
                              {16'h0010, 8'hA5, 1'b1, 1'b0});
        end
        n_vec++;
        if (t_done - t_end != 3 + int'(TwrCyc)) begin
            n_err++; $display("FAIL write_twr: got %0d want %0d", t_done - t_end, 3 + TwrCyc);
        end
        n_vec++;
        if (done_cnt[0] != 1 || done_cnt[1] != 0 || done_err !== 1'b0) begin
            n_err++; $display("FAIL write_done: got d0=%0d d1=%0d err=%b want 1 0 0",
                              done_cnt[0], done_cnt[1], done_err);
        end
        n_vec++;
        if (gnt0 !== 1'b0) begin n_err++; $display("FAIL write_gnt_drop: got %b want 0", gnt0); end
    endtask

    task automatic test_read();
        bit to;
        clear_mon();
        eeprom[16'h0010] = 8'h5A;
        wr1 = 1'b0; addr1 = 16'h0010; wdata1 = 8'h00; req1 = 1'b1;
        wait_done(StartHold + 60, to);
        req1 = 1'b0;
        n_vec++;
        if (to) begin n_err++; $display("FAIL read_done_seen: got none want done1"); end
        n_vec++;
        if (done_rdata !== 8'h5A) begin
            n_err++; $display("FAIL read_rdata: got %h want 5a", done_rdata);
        end
        n_vec++;
        if (t_done - t_end != 3) begin
            n_err++; $display("FAIL read_no_twr: got %0d want 3", t_done - t_end);
        end
        n_vec++;
        if (snap !== {16'h0010, 8'h00, 1'b0, 1'b1} || done_cnt[1] != 1 || done_cnt[0] != 0) begin
            n_err++; $display("FAIL read_cmd: got %h d1=%0d d0=%0d want %h 1 0", snap,
                              done_cnt[1], done_cnt[0], {16'h0010, 8'h00, 1'b0, 1'b1});
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int exp_order [4] = '{0, 1, 0, 1};
        apply_reset();
        wr0 = 1'b1; addr0 = 16'h0020; wdata0 = 8'h11;
        wr1 = 1'b0; addr1 = 16'h0020; wdata1 = 8'h00;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_done(StartHold + TwrCyc + 40, to);
            n_vec++;
            if (to) begin n_err++; $display("FAIL b2b_done_seen[%0d]: got none want done", i); end
            if (i == 1) begin
                n_vec++;
                if (done_rdata !== 8'h11) begin
                    n_err++; $display("FAIL b2b_readback: got %h want 11", done_rdata);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) tick();
        n_vec++;
        if (grant_q.size() != 4) begin
            n_err++; $display("FAIL b2b_grant_count: got %0d want 4", grant_q.size());
        end
        for (int i = 0; i < 4 && i < grant_q.size(); i++) begin
            n_vec++;
            if (grant_q[i] != exp_order[i]) begin
                n_err++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, grant_q[i], exp_order[i]);
            end
        end
        for (int i = 0; i < 3 && i + 1 < grant_t_q.size() && i < done_t_q.size(); i++) begin
            n_vec++;
            if (grant_t_q[i + 1] - done_t_q[i] != 2) begin
                n_err++; $display("FAIL b2b_regrant_gap[%0d]: got %0d want 2", i,
                                  grant_t_q[i + 1] - done_t_q[i]);
            end
        end
    endtask

    task automatic test_drop_req();
        bit to;
        bit in_busy;
        clear_mon();
        wr0 = 1'b0; addr0 = 16'h0030; req0 = 1'b1;
        in_busy = 1'b0;
        for (int i = 0; i < 40 && !in_busy; i++) begin
            tick();
            in_busy = (start_hi == int'(StartHold)) && !i2c_start;
        end
        req0 = 1'b0;
        wait_done(60, to);
        repeat (10) tick();
        n_vec++;
        if (to || !in_busy) begin
            n_err++; $display("FAIL drop_completes: got busy=%b timeout=%b want 1 0", in_busy, to);
        end
        n_vec++;
        if (done_cnt[0] != 1 || grant_q.size() != 1) begin
            n_err++; $display("FAIL drop_single_done: got done0=%0d grants=%0d want 1 1",
                              done_cnt[0], grant_q.size());
        end
    endtask

    task automatic test_reset_twr();
        bit to;
        bit seen_end;
        clear_mon();
        wr0 = 1'b1; addr0 = 16'h0040; wdata0 = 8'h77; req0 = 1'b1;
        seen_end = 1'b0;
        for (int i = 0; i < 60 && !seen_end; i++) begin
            tick();
            seen_end = i2c_end;
        end
        repeat (8) tick();
        sys_rst_n = 1'b0;
        req0 = 1'b0;
        @(posedge sys_clk);
        #1;
        n_vec++;
        if ({gnt0, gnt1, done0, done1, err, i2c_start, wr_en, rd_en} !== 8'b0 ||
            {byte_addr, wr_data, rdata} !== 32'h0 || !seen_end) begin
            n_err++; $display("FAIL twr_reset_outputs: got %b %h end=%b want 0 0 1",
                              {gnt0, gnt1, done0, done1, err, i2c_start, wr_en, rd_en},
                              {byte_addr, wr_data, rdata}, seen_end);
        end
        tick();
        sys_rst_n = 1'b1;
        repeat (5) tick();
        n_vec++;
        if (done_cnt[0] + done_cnt[1] != 0 || gnt0 !== 1'b0) begin
            n_err++; $display("FAIL twr_reset_no_done: got done=%0d gnt0=%b want 0 0",
                              done_cnt[0] + done_cnt[1], gnt0);
        end
        clear_mon();
        wr1 = 1'b0; addr1 = 16'h0040; req1 = 1'b1;
        wait_done(StartHold + 60, to);
        req1 = 1'b0;
        n_vec++;
        if (to || done_cnt[1] != 1 || done_rdata !== 8'h77) begin
            n_err++; $display("FAIL twr_reset_fresh: got timeout=%b done1=%0d rdata=%h want 0 1 77",
                              to, done_cnt[1], done_rdata);
        end
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit to;
        logic [7:0] r0;
        tick();
        clear_mon();
        r0 = rdata;
        ctrl_hang = 1'b1;
        wr1 = 1'b0; addr1 = 16'h0050; req1 = 1'b1;
        wait_done(TimeoutCyc + 50, to);
        req1 = 1'b0;
        ctrl_hang = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (to || t_done - t_gnt != int'(TimeoutCyc)) begin
            n_err++; $display("FAIL timeout_latency: got %0d (timeout=%b) want %0d",
                              t_done - t_gnt, to, TimeoutCyc);
        end
        n_vec++;
        if (done_err !== 1'b1 || err_cnt != 1 || done_rdata !== r0) begin
            n_err++; $display("FAIL timeout_err: got err=%b cnt=%0d rdata=%h want 1 1 %h",
                              done_err, err_cnt, done_rdata, r0);
        end
        n_vec++;
        if ({gnt0, gnt1, i2c_start} !== 3'b0) begin
            n_err++; $display("FAIL timeout_idle: got %b want 000", {gnt0, gnt1, i2c_start});
        end
    endtask
`endif

    task automatic test_random();
        bit          to;
        bit          pend [2];
        bit          pwr [2];
        logic [15:0] pad [2];
        logic [7:0]  pdt [2];
        logic [7:0]  ref_mem [logic [15:0]];
        int          ref_last;
        int          exp_who;
        int          obs_who;
        int          prev1;
        logic [7:0]  exp_rd;
        apply_reset();
        eeprom.delete();
        ref_last = 1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int t = 0; t < 16; t++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
                    pend[r] = 1'b1;
                    pwr[r]  = 1'($urandom_range(0, 1));
                    pad[r]  = 16'h0100 + 16'($urandom_range(0, 3));
                    pdt[r]  = 8'($urandom);
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[t % 2] = 1'b1; pwr[t % 2] = 1'b0; pad[t % 2] = 16'h0100; pdt[t % 2] = 8'h00;
            end
            wr0 = pwr[0]; addr0 = pad[0]; wdata0 = pdt[0]; req0 = pend[0];
            wr1 = pwr[1]; addr1 = pad[1]; wdata1 = pdt[1]; req1 = pend[1];
            exp_who = (pend[0] && pend[1]) ? 1 - ref_last : (pend[1] ? 1 : 0);
            prev1 = done_cnt[1];
            wait_done(StartHold + TwrCyc + 40, to);
            obs_who = (done_cnt[1] != prev1) ? 1 : 0;
            n_vec++;
            if (to || obs_who != exp_who) begin
                n_err++; $display("FAIL rand_owner[%0d]: got %0d (timeout=%b) want %0d",
                                  t, obs_who, to, exp_who);
            end
            if (!pwr[exp_who]) begin
                exp_rd = ref_mem.exists(pad[exp_who]) ? ref_mem[pad[exp_who]] : 8'hFF;
                n_vec++;
                if (done_rdata !== exp_rd) begin
                    n_err++; $display("FAIL rand_rdata[%0d]: got %h want %h", t, done_rdata, exp_rd);
                end
            end else begin
                ref_mem[pad[exp_who]] = pdt[exp_who];
            end
            n_vec++;
            if (done_err !== 1'b0) begin
                n_err++; $display("FAIL rand_err[%0d]: got %b want 0", t, done_err);
            end
            ref_last = exp_who;
            pend[exp_who] = 1'b0;
            if (exp_who == 0) req0 = 1'b0; else req1 = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_drop_req();
        test_reset_twr();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
